// File: rtl/uart_digit_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_digit_scheduler_pkg
// Description : Shared constants for the multiplexed seven-segment scheduler:
//               scan FSM state encoding, blank code and glyph patterns.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_digit_scheduler_pkg;

  // Scan FSM state encoding
  localparam logic [0:0] ST_SCAN  = 1'b0;
  localparam logic [0:0] ST_BLANK = 1'b1;

  // Digit value that turns every segment off
  localparam logic [7:0] BLANK_CODE = 8'hFF;

  // Active-low pattern with every segment dark
  localparam logic [6:0] SEG_OFF_N = 7'h7F;

  // Active-high glyphs, bit0=a .. bit6=g
  localparam logic [6:0] GLYPH_DASH = 7'h40;
  localparam logic [6:0] GLYPH_0    = 7'h3F;
  localparam logic [6:0] GLYPH_1    = 7'h06;
  localparam logic [6:0] GLYPH_2    = 7'h5B;
  localparam logic [6:0] GLYPH_3    = 7'h4F;
  localparam logic [6:0] GLYPH_4    = 7'h66;
  localparam logic [6:0] GLYPH_5    = 7'h6D;
  localparam logic [6:0] GLYPH_6    = 7'h7D;
  localparam logic [6:0] GLYPH_7    = 7'h07;
  localparam logic [6:0] GLYPH_8    = 7'h7F;
  localparam logic [6:0] GLYPH_9    = 7'h6F;

  // Larger of two integers, used to size the shared scan/blank counter
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_digit_scheduler_glyph.sv
`default_nettype none
// ============================================================================
// Module      : seg7_glyph_lut
// Description : Combinational digit-value to active-low segment lookup.
//               0..9 -> numeric glyph, 8'hFF -> dark, anything else -> dash.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_glyph_lut
  import uart_digit_scheduler_pkg::*;
(
  input  logic [7:0] code,
  output logic [6:0] seg_n
);

  // Map the stored byte to its inverted glyph; unknown values fall back to a dash
  always_comb begin
    seg_n = ~GLYPH_DASH;
    case (code)
      8'd0:       seg_n = ~GLYPH_0;
      8'd1:       seg_n = ~GLYPH_1;
      8'd2:       seg_n = ~GLYPH_2;
      8'd3:       seg_n = ~GLYPH_3;
      8'd4:       seg_n = ~GLYPH_4;
      8'd5:       seg_n = ~GLYPH_5;
      8'd6:       seg_n = ~GLYPH_6;
      8'd7:       seg_n = ~GLYPH_7;
      8'd8:       seg_n = ~GLYPH_8;
      8'd9:       seg_n = ~GLYPH_9;
      BLANK_CODE: seg_n = SEG_OFF_N;
      default:    seg_n = ~GLYPH_DASH;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/uart_digit_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : uart_digit_scheduler
// Description : Byte-stream driven multiplexed seven-segment display driver.
//               Incoming bytes shift into a digit store from the right; a
//               two-state scan FSM walks the digit positions with a blanking
//               gap between slots to suppress ghosting.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_digit_scheduler
  import uart_digit_scheduler_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  clear,
  output logic [6:0]            seg_n,
  output logic [NUM_DIGITS-1:0] an_n
);

  // One counter serves both states, so it is sized for the longer of the two
  localparam int CNT_W  = $clog2(max_int(SCAN_CYCLES, BLANK_CYCLES));
  localparam int SLOT_W = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0]  SCAN_LAST  = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(NUM_DIGITS - 1);

  logic [7:0]        digit [NUM_DIGITS];
  logic [0:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [SLOT_W-1:0] slot;
  logic              xfer;
  logic [6:0]        glyph_n;

  // Clear and reset both hold off the producer for that cycle
  assign in_ready = ~clear & ~rst;
  assign xfer     = in_valid & in_ready;

  // Digit store: clear/reset blank everything, a transfer shifts in at digit 0
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        digit[k] <= BLANK_CODE;
      end
    end else if (xfer) begin
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
        digit[k] <= digit[k-1];
      end
      digit[0] <= in_data;
    end
  end

  // Scan FSM: reset parks in BLANK on the last slot so the first scan is slot 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_BLANK;
      cnt   <= '0;
      slot  <= SLOT_LAST;
    end else begin
      case (state)
        ST_SCAN: begin
          if (cnt == SCAN_LAST) begin
            state <= ST_BLANK;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          if (cnt == BLANK_LAST) begin
            state <= ST_SCAN;
            cnt   <= '0;
            slot  <= (slot == SLOT_LAST) ? '0 : slot + SLOT_W'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  // Single shared decoder looks at whichever digit the FSM currently selects
  seg7_glyph_lut u_glyph (
    .code  (digit[slot]),
    .seg_n (glyph_n)
  );

  // Registered display outputs, one cycle behind the FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      an_n  <= '1;
      seg_n <= SEG_OFF_N;
    end else if (state == ST_SCAN) begin
      an_n  <= ~(NUM_DIGITS'(1) << slot);
      seg_n <= glyph_n;
    end else begin
      an_n  <= '1;
      seg_n <= SEG_OFF_N;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_digit_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_digit_scheduler
// Description : Self-checking bench for uart_digit_scheduler with a schedule
//               model based on elapsed cycles since reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_digit_scheduler;

  localparam int ND = 4;
  localparam int SC = 8;
  localparam int BC = 2;
  localparam int P  = SC + BC;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic [6:0]    seg_n;
  logic [ND-1:0] an_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_digit_scheduler #(
    .NUM_DIGITS   (ND),
    .SCAN_CYCLES  (SC),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .clear    (clear),
    .seg_n    (seg_n),
    .an_n     (an_n)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inverted glyph for a stored byte
  function automatic logic [6:0] glyph_of(input logic [7:0] v);
    case (v)
      8'd0: return ~7'h3F;
      8'd1: return ~7'h06;
      8'd2: return ~7'h5B;
      8'd3: return ~7'h4F;
      8'd4: return ~7'h66;
      8'd5: return ~7'h6D;
      8'd6: return ~7'h7D;
      8'd7: return ~7'h07;
      8'd8: return ~7'h7F;
      8'd9: return ~7'h6F;
      8'hFF: return 7'h7F;
      default: return ~7'h40;
    endcase
  endfunction

  // Model: t counts cycles since the reset edge; the schedule is a blank of BC
  // cycles followed by a repeating pattern of (SC scan + BC blank) per slot.
  logic [7:0]    md [ND];
  int            t = 0;
  bit            armed = 1'b0;
  logic [6:0]    exp_seg = 7'h7F;
  logic [ND-1:0] exp_an = '1;

  always @(posedge clk) begin
    check("in_ready", {31'd0, in_ready}, {31'd0, !(clear || rst)});
    if (rst) begin
      armed   = 1'b1;
      t       = 0;
      exp_an  = '1;
      exp_seg = 7'h7F;
      for (int k = 0; k < ND; k++) md[k] = 8'hFF;
    end else if (armed) begin
      int u;
      int s;
      exp_an  = '1;
      exp_seg = 7'h7F;
      if (t >= BC) begin
        u = (t - BC) % (ND * P);
        s = u / P;
        if ((u % P) < SC) begin
          exp_an  = ~(ND'(1) << s);
          exp_seg = glyph_of(md[s]);
        end
      end
      t++;
      if (clear) begin
        for (int k = 0; k < ND; k++) md[k] = 8'hFF;
      end else if (in_valid) begin
        for (int k = ND - 1; k >= 1; k--) md[k] = md[k-1];
        md[0] = in_data;
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (armed) begin
      check("seg_n_model", {25'd0, seg_n}, {25'd0, exp_seg});
      check("an_n_model", {28'd0, an_n}, {28'd0, exp_an});
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Wait for the start of a fresh scan of the slot whose an_n pattern is target
  task automatic wait_slot(input logic [ND-1:0] target, input string name);
    int n = 0;
    while (an_n === target && n < 200) begin tick(); n++; end
    while (an_n !== target && n < 200) begin tick(); n++; end
    if (an_n !== target) check({name, "_timeout"}, {28'd0, an_n}, {28'd0, target});
  endtask

  task automatic send(input logic [7:0] v);
    in_valid = 1'b1;
    in_data  = v;
    tick();
    in_valid = 1'b0;
  endtask

  logic [ND-1:0] hist [26];

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    tick(); tick();
    check("reset_an", {28'd0, an_n}, 32'hF);
    check("reset_seg", {25'd0, seg_n}, 32'h7F);
    rst = 1'b0;

    // Idle schedule after reset
    for (int i = 1; i <= 25; i++) begin
      tick();
      hist[i] = an_n;
      if (i == 3) check("idle_seg_slot0", {25'd0, seg_n}, 32'h7F);
    end
    check("idle_an_1", {28'd0, hist[1]}, 32'hF);
    check("idle_an_2", {28'd0, hist[2]}, 32'hF);
    check("idle_an_3", {28'd0, hist[3]}, 32'hE);
    check("idle_an_10", {28'd0, hist[10]}, 32'hE);
    check("idle_an_11", {28'd0, hist[11]}, 32'hF);
    check("idle_an_12", {28'd0, hist[12]}, 32'hF);
    check("idle_an_13", {28'd0, hist[13]}, 32'hD);
    check("idle_an_23", {28'd0, hist[23]}, 32'hB);

    // Transfers 1,2,3,4 back to back
    in_valid = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      in_data = 8'(v);
      tick();
    end
    in_valid = 1'b0;
    wait_slot(4'b1110, "slot0_a");
    check("digit0_is_4", {25'd0, seg_n}, 32'h19);
    wait_slot(4'b0111, "slot3_a");
    check("digit3_is_1", {25'd0, seg_n}, 32'h79);

    // 5, 0A, FF
    send(8'd5); send(8'h0A); send(8'hFF);
    wait_slot(4'b1011, "slot2_b");
    check("glyph_5", {25'd0, seg_n}, 32'h12);
    wait_slot(4'b1101, "slot1_b");
    check("glyph_dash", {25'd0, seg_n}, 32'h3F);
    wait_slot(4'b1110, "slot0_b");
    check("glyph_blank", {25'd0, seg_n}, 32'h7F);

    // Clear collides with a valid byte
    clear = 1'b1; in_valid = 1'b1; in_data = 8'd7;
    #1;
    check("clear_ready_low", {31'd0, in_ready}, 32'h0);
    tick();
    clear = 1'b0; in_valid = 1'b0;
    for (int s = 0; s < ND; s++) begin
      wait_slot(~(ND'(1) << s), "slot_clear");
      check("cleared_digit", {25'd0, seg_n}, 32'h7F);
    end

    // Reset mid-scan on slot 2 with a digit pending
    send(8'd9);
    wait_slot(4'b1011, "slot2_rst");
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_an", {28'd0, an_n}, 32'hF);
    tick();
    check("rst_blank_1", {28'd0, an_n}, 32'hF);
    tick();
    check("rst_blank_2", {28'd0, an_n}, 32'hF);
    tick();
    check("rst_first_slot", {28'd0, an_n}, 32'hE);
    check("rst_digit_blank", {25'd0, seg_n}, 32'h7F);

    // Six consecutive bytes; only the last four survive
    in_valid = 1'b1;
    for (int v = 1; v <= 6; v++) begin
      in_data = 8'(v);
      tick();
    end
    in_valid = 1'b0;
    wait_slot(4'b0111, "slot3_c");
    check("oldest_is_3", {25'd0, seg_n}, 32'h30);
    wait_slot(4'b1110, "slot0_c");
    check("newest_is_6", {25'd0, seg_n}, 32'h02);
    wait_slot(4'b1101, "slot1_c");
    check("digit1_is_5", {25'd0, seg_n}, 32'h12);

    repeat (45) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
